// File: rtl/cpu_pkg.sv
// Shared CPU definitions: canonical NOP, base opcodes, fetch-stage types.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Base opcodes, kept in step with control_unit's decoder
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   // Word handed to decode
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } out_word_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem request/response, EX redirect and decode handshake.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;

   // Fetch unit side
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc, id_ready,
      output if_valid, if_pc, if_instruction
   );

   // Memory / EX / decode side
   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc, id_ready,
      input  if_valid, if_pc, if_instruction
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO with flush and occupancy count.
// Push while full is accepted only together with a pop.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_pop   = pop && (count != '0);
   assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointers and occupancy; flush empties the queue in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage, no reset needed: entries are only read when counted
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and presents {pc, instr} to decode. Redirects flush the
// output buffer; responses still in flight are drained and discarded.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state, state_nxt;
   logic [31:0]   pc, pc_nxt;
   logic          req_valid, req_valid_nxt;
   logic [31:0]   req_addr, req_addr_nxt;

   logic          accept, resp_fire, ob_push, ob_pop, ob_empty, credit_ok;
   logic [CW-1:0] inflight, inflight_nxt, ob_count, buf_nxt;
   logic [31:0]   pq_head;
   out_word_t     ob_in, ob_head;

   assign accept    = req_valid && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored
   assign resp_fire = bus.imem_resp_valid && (inflight != '0);
   assign ob_empty  = (ob_count == '0);
   assign ob_push   = resp_fire && (state == FETCH) && !bus.redirect_valid;
   assign ob_pop    = !ob_empty && bus.id_ready && !bus.redirect_valid;
   assign ob_in     = '{pc: pq_head, instr: bus.imem_resp_data};

   // Occupancy after this cycle; a new request is issued only if it still fits
   assign inflight_nxt = inflight + CW'(accept) - CW'(resp_fire);
   assign buf_nxt      = bus.redirect_valid ? '0
                         : ob_count + CW'(ob_push) - CW'(ob_pop);
   assign credit_ok    = ({1'b0, inflight_nxt} + {1'b0, buf_nxt}) < (CW+1)'(DEPTH);

   // PC of each accepted request; its depth is the in-flight count
   fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (accept),
      .push_data (req_addr),
      .pop       (resp_fire),
      .pop_data  (pq_head),
      .count     (inflight)
   );

   // Words waiting for decode
   fetch_fifo #(.WIDTH($bits(out_word_t)), .DEPTH(DEPTH)) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect_valid),
      .push      (ob_push),
      .push_data (ob_in),
      .pop       (ob_pop),
      .pop_data  (ob_head),
      .count     (ob_count)
   );

   // FSM state, PC and registered request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         req_valid <= 1'b0;
         req_addr  <= RESET_PC;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         req_valid <= req_valid_nxt;
         req_addr  <= req_addr_nxt;
      end
   end

   // Next state: redirect wins; a stalled request is held; otherwise issue on credit
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_valid_nxt = 1'b0;
      req_addr_nxt  = req_addr;
      if (bus.redirect_valid) begin
         pc_nxt       = word_align(bus.redirect_pc);
         state_nxt    = (inflight_nxt != '0) ? DRAIN : FETCH;
         req_addr_nxt = pc_nxt;
      end else begin
         if (accept) pc_nxt = pc + 32'd4;
         if (state == DRAIN && inflight_nxt == '0) state_nxt = FETCH;
         if (req_valid && !bus.imem_req_ready) begin
            req_valid_nxt = 1'b1;
            req_addr_nxt  = req_addr;
         end else begin
            req_valid_nxt = (state_nxt == FETCH) && credit_ok;
            req_addr_nxt  = pc_nxt;
         end
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = req_addr;
   assign bus.if_valid       = !ob_empty;
   assign bus.if_pc          = ob_empty ? pc : ob_head.pc;
   assign bus.if_instruction = ob_empty ? NOP_INSTR : ob_head.instr;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural imem with variable latency,
// expected-PC tracker on every decode pop.
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] KEY = 32'h5EED_0000;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   instr_fetch_unit_if bus ();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   int          issued = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] snap_pc, snap_instr;
   rsp_t        q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: score any decode pop, then advance the memory model
   task automatic tick();
      logic        acc, pres, pop;
      logic [31:0] a;
      acc  = bus.imem_req_valid && bus.imem_req_ready && !rst;
      a    = bus.imem_req_addr;
      pres = bus.imem_resp_valid;
      pop  = bus.if_valid && bus.id_ready && !bus.redirect_valid && !rst;
      if (pop) begin
         chk("pop_pc", bus.if_pc, exp_pc);
         chk("pop_instr", bus.if_instruction, exp_pc ^ KEY);
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (acc) issued++;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) q.delete();
      else begin
         if (pres && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back('{due: cyc + lat - 1, data: a ^ KEY});
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = q[0].data;
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = 32'h0;
      end
   endtask

   task automatic run_pops(input string tag, input int n, input int budget);
      int target;
      target = pops + n;
      for (int i = 0; i < budget && pops < target; i++) tick();
      chk(tag, pops, target);
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
      exp_pc             = word_align(target);
   endtask

   initial begin
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.id_ready        = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);
      chk("rst_if_valid", bus.if_valid, 0);
      chk("rst_if_pc", bus.if_pc, 32'h0);
      chk("rst_if_instr", bus.if_instruction, NOP_INSTR);
      rst = 1'b0;

      // 1: first request one cycle after release, first word two cycles after accept
      chk("t1_no_req_c0", bus.imem_req_valid, 0);
      tick();
      chk("t1_req_valid_c1", bus.imem_req_valid, 1);
      chk("t1_req_addr_c1", bus.imem_req_addr, 32'h0);
      tick();
      chk("t1_if_valid_c2", bus.if_valid, 0);
      tick();
      chk("t1_if_valid_c3", bus.if_valid, 1);
      chk("t1_if_pc_c3", bus.if_pc, 32'h0);
      chk("t1_if_instr_c3", bus.if_instruction, 32'h0 ^ KEY);
      run_pops("t1_four_words", 4, 30);

      // 2: decode stall for 5 cycles
      for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
      chk("t2_wait_valid", bus.if_valid, 1);
      bus.id_ready = 1'b0;
      snap_pc    = bus.if_pc;
      snap_instr = bus.if_instruction;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_valid", bus.if_valid, 1);
         chk("t2_hold_pc", bus.if_pc, snap_pc);
         chk("t2_hold_instr", bus.if_instruction, snap_instr);
         chk("t2_credit", ((issued - pops) <= 2) ? 1 : 0, 1);
      end
      chk("t2_credit_full", issued - pops, 2);
      chk("t2_no_req", bus.imem_req_valid, 0);
      bus.id_ready = 1'b1;
      run_pops("t2_resume", 5, 30);

      // 3: redirect with two requests in flight
      lat = 3;
      for (int i = 0; i < 30 && !(q.size() == 2 && !bus.imem_resp_valid); i++) tick();
      chk("t3_two_inflight", q.size(), 2);
      redirect(32'h0000_0100);
      chk("t3_drain", 32'(dut.state), 32'(DRAIN));
      chk("t3_if_flushed", bus.if_valid, 0);
      chk("t3_no_req_drain", bus.imem_req_valid, 0);
      lat = 1;
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
      chk("t3_req_valid", bus.imem_req_valid, 1);
      chk("t3_req_addr", bus.imem_req_addr, 32'h0000_0100);
      chk("t3_fetch", 32'(dut.state), 32'(FETCH));
      run_pops("t3_words", 3, 30);

      // 4: unaligned redirect coinciding with a pop and a response
      for (int i = 0; i < 20 && !(bus.if_valid && bus.imem_resp_valid); i++) tick();
      chk("t4_collide", bus.if_valid && bus.imem_resp_valid, 1);
      redirect(32'h0000_0103);
      chk("t4_if_flushed", bus.if_valid, 0);
      chk("t4_if_instr_nop", bus.if_instruction, NOP_INSTR);
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
      chk("t4_req_addr", bus.imem_req_addr, 32'h0000_0100);
      run_pops("t4_words", 3, 30);

      // 5: memory back-pressure holds the request; redirect withdraws it
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
      chk("t5_req_valid", bus.imem_req_valid, 1);
      snap_pc = bus.imem_req_addr;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_hold_valid", bus.imem_req_valid, 1);
         chk("t5_hold_addr", bus.imem_req_addr, snap_pc);
      end
      redirect(32'h0000_0200);
      chk("t5_withdrawn", bus.imem_req_valid, 0);
      for (int i = 0; i < 20 && !bus.imem_req_valid; i++) tick();
      chk("t5_new_addr", bus.imem_req_addr, 32'h0000_0200);
      bus.imem_req_ready = 1'b1;
      run_pops("t5_words", 3, 30);

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFF8);
      run_pops("wrap_words", 4, 40);

      // 6: asynchronous reset mid-burst
      for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
      chk("t6_busy", bus.if_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_req_valid", bus.imem_req_valid, 0);
      chk("t6_req_addr", bus.imem_req_addr, 32'h0);
      chk("t6_if_valid", bus.if_valid, 0);
      chk("t6_if_pc", bus.if_pc, 32'h0);
      chk("t6_if_instr", bus.if_instruction, NOP_INSTR);
      tick();
      rst    = 1'b0;
      exp_pc = 32'h0;
      chk("t6_no_req_c0", bus.imem_req_valid, 0);
      tick();
      chk("t6_req_valid_c1", bus.imem_req_valid, 1);
      chk("t6_req_addr_c1", bus.imem_req_addr, 32'h0);
      run_pops("t6_words", 3, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
